// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================
// rv_enc_pkg: shared RV32I encoder types and constants
// Rev 1.0
// ============================================================
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] C_NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // True when v is representable as an nbits-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] sh;
    sh = 32'($signed(v) >>> (nbits - 1));
    return (sh == 32'h0) || (sh == 32'hFFFF_FFFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_imm_packer.sv
`default_nettype none
// ============================================================
// rv_imm_packer: combinational RV32I field packer with imm checks
// Rev 1.0
// ============================================================
module rv_imm_packer
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  fmt_e        w_fmt;
  logic [31:0] w_raw;
  logic        w_bad;

  assign w_fmt = fmt_e'(i_fmt);

  always_comb begin
    w_raw = NOP_WORD;
    w_bad = 1'b1;
    case (w_fmt)
      FMT_R: begin
        w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
        w_bad = 1'b0;
      end
      FMT_I: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
        w_bad = !fits_signed(i_imm, 12);
      end
      FMT_S: begin
        w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
        w_bad = !fits_signed(i_imm, 12);
      end
      FMT_B: begin
        w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_op};
        w_bad = !fits_signed(i_imm, 13) || i_imm[0];
      end
      FMT_U: begin
        w_raw = {i_imm[31:12], i_rd, i_op};
        w_bad = (i_imm[11:0] != 12'h000);
      end
      FMT_J: begin
        w_raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
        w_bad = !fits_signed(i_imm, 21) || i_imm[0];
      end
      default: begin
        w_raw = NOP_WORD;
        w_bad = 1'b1;
      end
    endcase
  end

  assign o_word = w_bad ? NOP_WORD : w_raw;
  assign o_err  = w_bad;

endmodule
`default_nettype wire

// File: rtl/instruction_stream_encoder.sv
`default_nettype none
// ============================================================
// instruction_stream_encoder: burst RV32I encoder with addressed output
// Rev 1.0
// ============================================================
module instruction_stream_encoder
  import rv_enc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [LEN_W-1:0]  err_count
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_out_addr;
  logic [LEN_W-1:0]  r_remaining, r_err_count;
  logic [31:0]       r_word;
  logic              r_out_valid, r_out_err, r_done;
  logic [31:0]       w_word;
  logic              w_err, w_in_ready, w_accept, w_out_hs;

  rv_imm_packer #(.NOP_WORD(NOP_WORD)) u_packer (
    .i_fmt    (in_fmt),
    .i_op     (in_op),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_imm    (in_imm),
    .o_word   (w_word),
    .o_err    (w_err)
  );

  assign w_in_ready = (r_state == ST_LOAD) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && (length != '0)) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_accept && (r_remaining == LEN_W'(1))) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_err_count <= '0;
      r_word      <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_addr      <= start_addr;
        r_remaining <= length;
        r_err_count <= '0;
        if (length == '0) r_done <= 1'b1;
      end
      // A new word may replace the held one only when it is leaving this cycle.
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_word      <= w_word;
        r_out_addr  <= r_addr;
        r_out_err   <= w_err;
        r_addr      <= r_addr + ADDR_W'(4);
        r_remaining <= r_remaining - LEN_W'(1);
        if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + LEN_W'(1);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if ((r_state == ST_DRAIN) && w_out_hs) r_done <= 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_word  = r_word;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/instruction_stream_encoder.md
# instruction_stream_encoder

- Sequential RV32I encoder, the inverse of the core's instruction decoder.
- Accepts a burst of field bundles (format, opcode, funct3/funct7, registers, 32-bit immediate) over a valid/ready stream.
- For each bundle it packs a legal 32-bit instruction word and checks the immediate for range and alignment.
- Emits each word with an auto-incrementing byte address, so a test harness or boot loader can write programs into instruction memory.

## Interface
Parameters:
- ADDR_W, 32, width of out_addr and start_addr
- LEN_W, 16, width of length and err_count
- NOP_WORD, 32'h0000_0013, word substituted on encode error (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a burst; ignored unless IDLE
- start_addr  in  ADDR_W  byte address of the first word, sampled on start
- length  in  LEN_W  number of bundles in the burst, sampled on start
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse when the burst completes
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
- in_op  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_rd / in_rs1 / in_rs2  in  5 each  register numbers
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- out_err  out  1  encode error; out_word is NOP_WORD
- err_count  out  LEN_W  errors in the current burst, saturating

## Operation
Encoding (unused fields ignored):
- R: {funct7, rs2, rs1, funct3, rd, op}
- I: {imm[11:0], rs1, funct3, rd, op}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
- U: {imm[31:12], rd, op}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}

Error rules:
- I/S: imm must lie in -2048..2047.
- B: imm must lie in -4096..4094 and imm[0]=0.
- J: imm must lie in -1048576..1048574 and imm[0]=0.
- U: imm[11:0] must be 0.
- in_fmt 6 or 7 is always an error.
- On any error: out_word=NOP_WORD, out_err=1, err_count increments (saturates at all-ones).

FSM states:
- IDLE: in_ready=0. start loads addr, remaining=length, clears err_count. Goes to LOAD if length≠0; otherwise stays IDLE and pulses done next cycle.
- LOAD: accepts bundles and decrements remaining on each accept. Goes to DRAIN when the last bundle is accepted.
- DRAIN: in_ready=0. On the output handshake of the last word, goes to IDLE with a done pulse in that same transition.

Address: out_addr is captured per word from addr; addr += 4 on each input accept, wrapping modulo 2^ADDR_W.

## Timing
- Reset values: out_valid=0, out_word=0, out_addr=0, out_err=0, busy=0, done=0, err_count=0, state IDLE.
- Latency: word valid the cycle after the input handshake; one output register.
- in_ready = (state==LOAD) && (!out_valid || out_ready). Accept and output in the same cycle sustains 1 word/clock.
- Backpressure: out_word, out_addr and out_err hold stable while out_valid && !out_ready.
- done is registered: it asserts the cycle after the final out handshake, together with busy dropping.
- start while busy has no effect.
- rst_n low mid-burst aborts immediately and asynchronously; the burst is not resumed.

## Structure
- Shared package rv_enc_pkg holds:
  - fmt_e enum (R, I, S, B, U, J)
  - NOP_WORD default
  - RV32I opcode constants (OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, ...)
  - state enum (IDLE, LOAD, DRAIN)
- Sub-module rv_imm_packer: combinational; fmt + fields + imm in, word + err out.
- The top level owns the FSM, counters, address and output register.

## Test plan
- Burst start_addr=0x100, length=1, I, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_word=0x00500093, out_addr=0x100, out_err=0; done one cycle after the handshake.
- B, op=0x63, rs1=1, rs2=2, f3=0, imm=-8 -> 0xFE208CE3; J, op=0x6F, rd=1, imm=2048 -> 0x001000EF; U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors: I imm=2048; U imm=0x12345001; B imm=3; fmt=7 -> each gives out_word=0x00000013, out_err=1; err_count=4 at done.
- Length 4 at 0xFFFFFFF8 with out_ready toggled 1/0 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; outputs stable while stalled; no words lost or duplicated; done exactly once.
- length=0 start -> done pulses the next cycle, busy never asserts; a start pulse during LOAD is ignored.
- rst_n pulled low in DRAIN with out_valid=1 -> all outputs drop to reset values immediately; a fresh burst then encodes correctly.
